// File: rtl/sdram_responder_pkg.sv
// sdram_responder_pkg
//   Shared definitions for the SDRAM device-side responder: command
//   encodings ({cke, cs_n, ras_n, cas_n, we_n}), mode-register field
//   positions, protocol-violation codes, init FSM states and small
//   decode helpers used by the responder and its read pipeline.
package sdram_responder_pkg;

    typedef logic [4:0] cmd_t;

    localparam cmd_t CMD_NOP          = 5'b1_0111;
    localparam cmd_t CMD_ACTIVE       = 5'b1_0011;
    localparam cmd_t CMD_READ         = 5'b1_0101;
    localparam cmd_t CMD_WRITE        = 5'b1_0100;
    localparam cmd_t CMD_BST          = 5'b1_0110;
    localparam cmd_t CMD_PRECHARGE    = 5'b1_0010;
    localparam cmd_t CMD_AUTO_REFRESH = 5'b1_0001;
    localparam cmd_t CMD_MRS          = 5'b1_0000;

    // Mode register field positions
    localparam int MR_WRITE_MODE = 9;   // 1 = single write, 0 = burst write
    localparam int MR_CL_HI      = 6;
    localparam int MR_CL_LO      = 4;
    localparam int MR_BT         = 3;   // must be 0 (sequential)
    localparam int MR_BL_HI      = 2;
    localparam int MR_BL_LO      = 0;

    localparam logic [2:0] BL_FULL_PAGE = 3'b111;

    typedef enum logic [2:0] {
        ERR_NONE         = 3'd0,
        ERR_INIT         = 3'd1,   // command before init sequence complete
        ERR_IDLE_BANK    = 3'd2,   // READ/WRITE to a closed bank
        ERR_BANK_OPEN    = 3'd3,   // ACTIVE to an already open bank
        ERR_TRCD         = 3'd4,   // READ/WRITE too soon after ACTIVE
        ERR_REFRESH_OPEN = 3'd5,   // AUTO_REFRESH/MRS with a bank open
        ERR_MODE         = 3'd6,   // unsupported mode-register value
        ERR_WR_DURING_RD = 3'd7    // WRITE while read data still in flight
    } err_code_t;

    typedef enum logic [2:0] {
        INIT_WAIT_PRE,
        INIT_WAIT_AR1,
        INIT_WAIT_AR2,
        INIT_WAIT_MRS,
        INIT_READY
    } init_state_t;

    // Only CL 2/3, sequential bursts, and BL 1/2/4/8/full-page are modelled.
    function automatic logic mode_valid(input logic [6:0] mr);
        logic cl_ok;
        logic bl_ok;
        cl_ok = (mr[MR_CL_HI:MR_CL_LO] == 3'b010) || (mr[MR_CL_HI:MR_CL_LO] == 3'b011);
        bl_ok = (mr[MR_BL_HI] == 1'b0) || (mr[MR_BL_HI:MR_BL_LO] == BL_FULL_PAGE);
        return cl_ok && !mr[MR_BT] && bl_ok;
    endfunction

    // Burst length for the fixed-length codes; full page is flagged separately.
    function automatic logic [3:0] burst_len(input logic [2:0] code);
        case (code)
            3'b001:  return 4'd2;
            3'b010:  return 4'd4;
            3'b011:  return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [23:0] store_addr(input logic [1:0] ba,
                                               input logic [12:0] row,
                                               input logic [8:0] col);
        return {ba, row, col};
    endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// sdram_responder_if
//   SDRAM command/data bus between the controller (master) and the
//   device-side responder (slave).
//   cke, cs_n, ras_n, cas_n, we_n : command strobes
//   ba[1:0], addr[12:0]           : bank / row-column-mode address
//   dq_in[15:0]                   : write data from controller
//   dq_out[15:0], dq_oe           : read data and its valid / output enable
interface sdram_responder_if;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;

    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, ba, addr, dq_in,
        input  dq_out, dq_oe
    );

    modport slave (
        input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, dq_in,
        output dq_out, dq_oe
    );
endinterface

// File: rtl/sdram_responder_rd_pipe.sv
// sdram_rd_pipe
//   Backing store plus CAS-latency pipeline. A read issued at edge T is
//   carried through a shift register of {valid, index}; at edge T+CL the
//   store is read (registered) so the word is on dq_out during cycle T+CL.
//   Ports:
//     clk_100m, rst_n          : clock, async active-low reset
//     cl3                      : 1 = CAS latency 3, 0 = CAS latency 2
//     issue_valid, issue_idx   : read column issued this edge
//     wr_en, wr_idx, wr_data   : store write port
//     pending                  : a read word has been issued but not yet driven
//     dq_out, dq_oe            : read data and valid
module sdram_rd_pipe #(
    parameter int MEM_AW = 10
) (
    input  logic              clk_100m,
    input  logic              rst_n,
    input  logic              cl3,
    input  logic              issue_valid,
    input  logic [MEM_AW-1:0] issue_idx,
    input  logic              wr_en,
    input  logic [MEM_AW-1:0] wr_idx,
    input  logic [15:0]       wr_data,
    output logic              pending,
    output logic [15:0]       dq_out,
    output logic              dq_oe
);
    localparam int DEPTH = 3;   // enough stages for the largest CL

    logic [DEPTH-1:0]        valid_reg;
    logic [DEPTH*MEM_AW-1:0] idx_reg;      // stage k at [k*MEM_AW +: MEM_AW]
    logic [15:0]             mem [2**MEM_AW];
    logic [15:0]             rd_word_reg;
    logic                    oe_reg;
    logic                    tap_valid;
    logic [MEM_AW-1:0]       tap_idx;

    // Stage CL-1 holds the issue from edge T-CL+... i.e. the word due now.
    assign tap_valid = cl3 ? valid_reg[2] : valid_reg[1];
    assign tap_idx   = cl3 ? idx_reg[3*MEM_AW-1 -: MEM_AW] : idx_reg[2*MEM_AW-1 -: MEM_AW];
    assign pending   = cl3 ? |valid_reg[2:0] : |valid_reg[1:0];

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            oe_reg    <= 1'b0;
        end else begin
            valid_reg <= {valid_reg[DEPTH-2:0], issue_valid};
            oe_reg    <= tap_valid;
        end
    end

    // Index stages and store carry no reset so the store maps onto block RAM.
    always_ff @(posedge clk_100m) begin
        idx_reg <= {idx_reg[(DEPTH-1)*MEM_AW-1:0], issue_idx};
    end

    always_ff @(posedge clk_100m) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        rd_word_reg <= mem[tap_idx];
    end

    // Gate the unreset RAM output so the bus reads 0 whenever nothing is valid.
    assign dq_out = oe_reg ? rd_word_reg : 16'h0000;
    assign dq_oe  = oe_reg;

endmodule

// File: rtl/sdram_responder.sv
// sdram_responder
//   SDRAM device-side model: decodes the controller's command bus, tracks
//   the init sequence, mode register and per-bank open rows, serves
//   read/write bursts from an on-chip store and flags protocol violations.
//   Ports:
//     clk_100m, rst_n : clock, async active-low reset
//     sdram           : command/address/data bus (slave modport)
//     init_done       : init sequence (PRE-all, AR, AR, MRS) completed
//     err_flag        : sticky violation flag
//     err_code        : code of most recent violation
//   T_RCD must be >= 1. A10 on READ/WRITE (auto-precharge) is not modelled.
module sdram_responder
    import sdram_responder_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int T_RCD  = 2
) (
    input  logic               clk_100m,
    input  logic               rst_n,
    sdram_responder_if.slave   sdram,
    output logic               init_done,
    output logic               err_flag,
    output logic [2:0]         err_code
);
    localparam int RCD_W = (T_RCD < 2) ? 1 : $clog2(T_RCD + 1);
    localparam logic [RCD_W-1:0] RCD_MAX = RCD_W'(T_RCD);

    cmd_t        cmd;
    logic        a10;
    init_state_t state_reg, state_next;

    logic [3:0]  bank_open;
    logic [12:0] bank_row [4];
    logic [3:0]  rcd_ok;

    logic        mode_cl3_reg;
    logic [2:0]  mode_bl_reg;
    logic        mode_wr_single_reg;

    logic        err_flag_reg;
    err_code_t   err_code_reg;

    logic        burst_active_reg;
    logic        burst_wr_reg;
    logic        burst_full_reg;
    logic [2:0]  burst_left_reg;
    logic [1:0]  burst_bank_reg;
    logic [12:0] burst_row_reg;
    logic [8:0]  burst_col_reg;

    // decode results
    logic        err_set;
    err_code_t   err_val;
    logic        act_ok;
    logic        pre_ok;
    logic        mrs_ok;
    logic        rw_ok;
    logic        term;
    logic        rd_pending;

    // issue path
    logic        issue_rd;
    logic        issue_wr;
    logic [1:0]  issue_bank;
    logic [12:0] issue_row;
    logic [8:0]  issue_col;
    logic [MEM_AW-1:0] issue_idx;
    logic [3:0]  start_len;
    logic        start_full;

    assign cmd = {sdram.cke, sdram.cs_n, sdram.ras_n, sdram.cas_n, sdram.we_n};
    assign a10 = sdram.addr[10];

    //------------------------------------------------------------------
    // Per-bank open flag, row and ACTIVE-to-access counter
    //------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic             open_reg;
            logic [12:0]      row_reg;
            logic [RCD_W-1:0] rcd_cnt_reg;
            logic             hit;

            assign hit = (sdram.ba == 2'(gi));

            // Counter is set to 1 on ACTIVE: it holds the number of edges
            // that will have elapsed when the next command is sampled.
            always_ff @(posedge clk_100m or negedge rst_n) begin
                if (!rst_n) begin
                    open_reg    <= 1'b0;
                    row_reg     <= '0;
                    rcd_cnt_reg <= RCD_MAX;
                end else if (act_ok && hit) begin
                    open_reg    <= 1'b1;
                    row_reg     <= sdram.addr;
                    rcd_cnt_reg <= RCD_W'(1);
                end else begin
                    if (pre_ok && (a10 || hit)) begin
                        open_reg <= 1'b0;
                    end
                    if (rcd_cnt_reg < RCD_MAX) begin
                        rcd_cnt_reg <= rcd_cnt_reg + RCD_W'(1);
                    end
                end
            end

            assign bank_open[gi] = open_reg;
            assign bank_row[gi]  = row_reg;
            assign rcd_ok[gi]    = (rcd_cnt_reg >= RCD_MAX);
        end
    endgenerate

    //------------------------------------------------------------------
    // Command decode and init FSM next state
    //------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        err_set    = 1'b0;
        err_val    = ERR_NONE;
        act_ok     = 1'b0;
        pre_ok     = 1'b0;
        mrs_ok     = 1'b0;
        rw_ok      = 1'b0;
        // Any selected READ/WRITE/BST/PRECHARGE ends the current burst,
        // even if the command itself is rejected.
        term       = (cmd == CMD_READ) || (cmd == CMD_WRITE) ||
                     (cmd == CMD_BST)  || (cmd == CMD_PRECHARGE);

        if (state_reg != INIT_READY) begin
            // Only the next command of the init sequence is accepted.
            // cke=0 / cs_n=1 never match any encoding, so they fall through.
            if ((cmd == CMD_PRECHARGE) && a10 && (state_reg == INIT_WAIT_PRE)) begin
                pre_ok     = 1'b1;
                state_next = INIT_WAIT_AR1;
            end else if ((cmd == CMD_AUTO_REFRESH) && (state_reg == INIT_WAIT_AR1)) begin
                state_next = INIT_WAIT_AR2;
            end else if ((cmd == CMD_AUTO_REFRESH) && (state_reg == INIT_WAIT_AR2)) begin
                state_next = INIT_WAIT_MRS;
            end else if ((cmd == CMD_MRS) && (state_reg == INIT_WAIT_MRS)) begin
                if (mode_valid(sdram.addr[6:0])) begin
                    mrs_ok     = 1'b1;
                    state_next = INIT_READY;
                end else begin
                    err_set = 1'b1;
                    err_val = ERR_MODE;
                end
            end else if (sdram.cke && !sdram.cs_n && (cmd != CMD_NOP)) begin
                err_set = 1'b1;
                err_val = ERR_INIT;
            end
        end else begin
            case (cmd)
                CMD_ACTIVE: begin
                    if (bank_open[sdram.ba]) begin
                        err_set = 1'b1;
                        err_val = ERR_BANK_OPEN;
                    end else begin
                        act_ok = 1'b1;
                    end
                end
                CMD_READ, CMD_WRITE: begin
                    if (!bank_open[sdram.ba]) begin
                        err_set = 1'b1;
                        err_val = ERR_IDLE_BANK;
                    end else begin
                        rw_ok = 1'b1;
                        // Bus turnaround is reported ahead of tRCD when both apply.
                        if ((cmd == CMD_WRITE) && rd_pending) begin
                            err_set = 1'b1;
                            err_val = ERR_WR_DURING_RD;
                        end else if (!rcd_ok[sdram.ba]) begin
                            err_set = 1'b1;
                            err_val = ERR_TRCD;
                        end
                    end
                end
                CMD_PRECHARGE: pre_ok = 1'b1;
                CMD_AUTO_REFRESH: begin
                    if (|bank_open) begin
                        err_set = 1'b1;
                        err_val = ERR_REFRESH_OPEN;
                    end
                end
                CMD_MRS: begin
                    if (|bank_open) begin
                        err_set = 1'b1;
                        err_val = ERR_REFRESH_OPEN;
                    end else if (!mode_valid(sdram.addr[6:0])) begin
                        err_set = 1'b1;
                        err_val = ERR_MODE;
                    end else begin
                        mrs_ok = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= INIT_WAIT_PRE;
        end else begin
            state_reg <= state_next;
        end
    end

    //------------------------------------------------------------------
    // Mode register and error reporting
    //------------------------------------------------------------------
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            mode_cl3_reg       <= 1'b1;
            mode_bl_reg        <= 3'b000;
            mode_wr_single_reg <= 1'b1;
            err_flag_reg       <= 1'b0;
            err_code_reg       <= ERR_NONE;
        end else begin
            if (mrs_ok) begin
                // Valid CL values 010/011 differ only in A4.
                mode_cl3_reg       <= sdram.addr[MR_CL_LO];
                mode_bl_reg        <= sdram.addr[MR_BL_HI:MR_BL_LO];
                mode_wr_single_reg <= sdram.addr[MR_WRITE_MODE];
            end
            if (err_set) begin
                err_flag_reg <= 1'b1;
                err_code_reg <= err_val;
            end
        end
    end

    //------------------------------------------------------------------
    // Burst generator: the starting column issues on the command edge,
    // the remainder follows one column per edge, wrapping inside the page.
    //------------------------------------------------------------------
    always_comb begin
        issue_rd   = 1'b0;
        issue_wr   = 1'b0;
        issue_bank = burst_bank_reg;
        issue_row  = burst_row_reg;
        issue_col  = burst_col_reg;
        start_full = 1'b0;
        start_len  = 4'd1;
        if (rw_ok) begin
            issue_bank = sdram.ba;
            issue_row  = bank_row[sdram.ba];
            issue_col  = sdram.addr[8:0];
            issue_rd   = (cmd == CMD_READ);
            issue_wr   = (cmd == CMD_WRITE);
            if (!(issue_wr && mode_wr_single_reg)) begin
                start_full = (mode_bl_reg == BL_FULL_PAGE);
                start_len  = burst_len(mode_bl_reg);
            end
        end else if (burst_active_reg && !term) begin
            issue_rd = !burst_wr_reg;
            issue_wr = burst_wr_reg;
        end
    end

    assign issue_idx = MEM_AW'(store_addr(issue_bank, issue_row, issue_col));

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            burst_active_reg <= 1'b0;
            burst_wr_reg     <= 1'b0;
            burst_full_reg   <= 1'b0;
            burst_left_reg   <= '0;
            burst_bank_reg   <= '0;
            burst_row_reg    <= '0;
            burst_col_reg    <= '0;
        end else if (rw_ok) begin
            burst_active_reg <= start_full || (start_len > 4'd1);
            burst_wr_reg     <= (cmd == CMD_WRITE);
            burst_full_reg   <= start_full;
            burst_left_reg   <= 3'(start_len - 4'd1);
            burst_bank_reg   <= sdram.ba;
            burst_row_reg    <= bank_row[sdram.ba];
            burst_col_reg    <= sdram.addr[8:0] + 9'd1;
        end else if (term) begin
            burst_active_reg <= 1'b0;
        end else if (burst_active_reg) begin
            burst_col_reg <= burst_col_reg + 9'd1;
            if (!burst_full_reg) begin
                burst_left_reg <= burst_left_reg - 3'd1;
                if (burst_left_reg == 3'd1) begin
                    burst_active_reg <= 1'b0;
                end
            end
        end
    end

    sdram_rd_pipe #(
        .MEM_AW (MEM_AW)
    ) u_rd_pipe (
        .clk_100m    (clk_100m),
        .rst_n       (rst_n),
        .cl3         (mode_cl3_reg),
        .issue_valid (issue_rd),
        .issue_idx   (issue_idx),
        .wr_en       (issue_wr),
        .wr_idx      (issue_idx),
        .wr_data     (sdram.dq_in),
        .pending     (rd_pending),
        .dq_out      (sdram.dq_out),
        .dq_oe       (sdram.dq_oe)
    );

    assign init_done = (state_reg == INIT_READY);
    assign err_flag  = err_flag_reg;
    assign err_code  = err_code_reg;

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder
//   Directed bench: init sequence, CL3/BL4 write-then-read, full-page read
//   with wrap and burst stop, CL2 read, error reporting (idle bank, tRCD,
//   write during read) and reset in the middle of a read burst.
module tb_sdram_responder;
    import sdram_responder_pkg::*;

    logic       clk_100m = 1'b0;
    logic       rst_n    = 1'b0;
    logic       init_done;
    logic       err_flag;
    logic [2:0] err_code;

    int n_assert = 0;
    int n_fail   = 0;

    sdram_responder_if sdram();

    sdram_responder #(
        .MEM_AW (10),
        .T_RCD  (2)
    ) dut (
        .clk_100m  (clk_100m),
        .rst_n     (rst_n),
        .sdram     (sdram),
        .init_done (init_done),
        .err_flag  (err_flag),
        .err_code  (err_code)
    );

    always #5 clk_100m = ~clk_100m;

    // Apply one command for the next rising edge, then return to NOP.
    // Returns 1 ns after the edge, where outputs are checked.
    task automatic drive(input cmd_t c, input logic [1:0] b,
                         input logic [12:0] a, input logic [15:0] d);
        {sdram.cke, sdram.cs_n, sdram.ras_n, sdram.cas_n, sdram.we_n} = c;
        sdram.ba    = b;
        sdram.addr  = a;
        sdram.dq_in = d;
        @(posedge clk_100m);
        #1;
        {sdram.cke, sdram.cs_n, sdram.ras_n, sdram.cas_n, sdram.we_n} = CMD_NOP;
        sdram.dq_in = 16'h0000;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(CMD_NOP, 2'd0, 13'h000, 16'h0000);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [8:0]  wcol  [5];
    logic [15:0] wdata [5];

    initial begin
        {sdram.cke, sdram.cs_n, sdram.ras_n, sdram.cas_n, sdram.we_n} = CMD_NOP;
        sdram.ba    = 2'd0;
        sdram.addr  = 13'h000;
        sdram.dq_in = 16'h0000;

        // ---- reset values ----
        repeat (3) @(posedge clk_100m);
        #1;
        chk("rst_dq_oe",     16'(sdram.dq_oe), 16'h0);
        chk("rst_dq_out",    sdram.dq_out,     16'h0);
        chk("rst_init_done", 16'(init_done),   16'h0);
        chk("rst_err_flag",  16'(err_flag),    16'h0);
        chk("rst_err_code",  16'(err_code),    16'h0);
        rst_n = 1'b1;
        #2;

        // ---- init: PRE-all, AR, AR, MRS 0x232 (CL3, BL4, single write) ----
        drive(CMD_PRECHARGE, 2'd0, 13'h400, 16'h0);
        drive(CMD_AUTO_REFRESH, 2'd0, 13'h000, 16'h0);
        drive(CMD_AUTO_REFRESH, 2'd0, 13'h000, 16'h0);
        chk("init_before_mrs", 16'(init_done), 16'h0);
        drive(CMD_MRS, 2'd0, 13'h232, 16'h0);
        chk("init_done", 16'(init_done), 16'h1);
        chk("init_no_err", 16'(err_flag), 16'h0);

        // ---- CL3 BL4 read after single writes ----
        drive(CMD_ACTIVE, 2'd1, 13'h005, 16'h0);
        nop(1);
        wcol[0] = 9'h010; wdata[0] = 16'hA5A5;
        wcol[1] = 9'h011; wdata[1] = 16'h1111;
        wcol[2] = 9'h012; wdata[2] = 16'h2222;
        wcol[3] = 9'h013; wdata[3] = 16'h3333;
        for (int i = 0; i < 4; i++) drive(CMD_WRITE, 2'd1, {4'h0, wcol[i]}, wdata[i]);
        chk("wr_no_err", 16'(err_flag), 16'h0);
        drive(CMD_READ, 2'd1, 13'h010, 16'h0);        // T
        chk("cl3_oe_T", 16'(sdram.dq_oe), 16'h0);
        nop(2);                                       // T+2
        chk("cl3_oe_T2", 16'(sdram.dq_oe), 16'h0);
        for (int i = 0; i < 4; i++) begin             // T+3..T+6
            nop(1);
            chk("cl3_oe", 16'(sdram.dq_oe), 16'h1);
            chk("cl3_dq", sdram.dq_out, wdata[i]);
        end
        nop(1);                                       // T+7
        chk("cl3_oe_end", 16'(sdram.dq_oe), 16'h0);

        // ---- full page with wrap, stopped by BST ----
        drive(CMD_PRECHARGE, 2'd0, 13'h400, 16'h0);
        drive(CMD_MRS, 2'd0, 13'h237, 16'h0);
        drive(CMD_ACTIVE, 2'd1, 13'h005, 16'h0);
        nop(1);
        wcol[0] = 9'h1FE; wdata[0] = 16'hBEEF;
        wcol[1] = 9'h1FF; wdata[1] = 16'hCAFE;
        wcol[2] = 9'h000; wdata[2] = 16'h0123;
        wcol[3] = 9'h001; wdata[3] = 16'h4567;
        wcol[4] = 9'h002; wdata[4] = 16'h89AB;
        for (int i = 0; i < 5; i++) drive(CMD_WRITE, 2'd1, {4'h0, wcol[i]}, wdata[i]);
        chk("fp_no_err", 16'(err_flag), 16'h0);
        drive(CMD_READ, 2'd1, 13'h1FE, 16'h0);        // T
        nop(3);                                       // T+3
        chk("fp_oe_T3", 16'(sdram.dq_oe), 16'h1);
        chk("fp_dq_1fe", sdram.dq_out, 16'hBEEF);
        drive(CMD_BST, 2'd0, 13'h000, 16'h0);         // T+4
        chk("fp_dq_1ff", sdram.dq_out, 16'hCAFE);
        nop(1);
        chk("fp_dq_000", sdram.dq_out, 16'h0123);
        nop(1);
        chk("fp_dq_001", sdram.dq_out, 16'h4567);
        nop(1);                                       // T+7
        chk("fp_oe_T7", 16'(sdram.dq_oe), 16'h0);

        // ---- CL2 ----
        drive(CMD_PRECHARGE, 2'd0, 13'h400, 16'h0);
        drive(CMD_MRS, 2'd0, 13'h222, 16'h0);
        drive(CMD_ACTIVE, 2'd1, 13'h005, 16'h0);
        nop(1);
        drive(CMD_READ, 2'd1, 13'h010, 16'h0);        // T
        nop(1);
        chk("cl2_oe_T1", 16'(sdram.dq_oe), 16'h0);
        nop(1);                                       // T+2
        chk("cl2_oe_T2", 16'(sdram.dq_oe), 16'h1);
        chk("cl2_dq_T2", sdram.dq_out, 16'hA5A5);
        nop(1);
        chk("cl2_dq_T3", sdram.dq_out, 16'h1111);
        nop(3);                                       // T+6
        chk("cl2_oe_end", 16'(sdram.dq_oe), 16'h0);
        chk("cl2_no_err", 16'(err_flag), 16'h0);

        // ---- READ to idle bank ----
        drive(CMD_READ, 2'd2, 13'h000, 16'h0);
        chk("idle_err_flag", 16'(err_flag), 16'h1);
        chk("idle_err_code", 16'(err_code), 16'h2);
        nop(2);
        chk("idle_oe", 16'(sdram.dq_oe), 16'h0);
        nop(1);
        chk("idle_oe2", 16'(sdram.dq_oe), 16'h0);

        // ---- tRCD violation, still executed; bank 2 row 5 aliases bank 1 ----
        drive(CMD_ACTIVE, 2'd2, 13'h005, 16'h0);
        drive(CMD_READ, 2'd2, 13'h010, 16'h0);        // T
        chk("trcd_err_code", 16'(err_code), 16'h4);
        nop(2);                                       // T+2
        chk("trcd_oe", 16'(sdram.dq_oe), 16'h1);
        chk("trcd_dq", sdram.dq_out, 16'hA5A5);
        nop(1);
        chk("trcd_dq2", sdram.dq_out, 16'h1111);
        nop(4);

        // ---- WRITE while read in flight: error 7, write done, burst cut ----
        drive(CMD_READ, 2'd2, 13'h010, 16'h0);        // R
        drive(CMD_WRITE, 2'd2, 13'h020, 16'h7777);    // R+1
        chk("wrrd_err_code", 16'(err_code), 16'h7);
        nop(1);                                       // R+2
        chk("wrrd_dq", sdram.dq_out, 16'hA5A5);
        nop(1);                                       // R+3
        chk("wrrd_oe_cut", 16'(sdram.dq_oe), 16'h0);
        drive(CMD_READ, 2'd2, 13'h020, 16'h0);        // S
        nop(2);                                       // S+2
        chk("wrrd_readback", sdram.dq_out, 16'h7777);
        chk("wrrd_code_kept", 16'(err_code), 16'h7);
        nop(4);

        // ---- reset in the middle of a read burst ----
        drive(CMD_READ, 2'd1, 13'h010, 16'h0);        // T
        nop(2);                                       // T+2
        chk("mid_oe_before", 16'(sdram.dq_oe), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oe",        16'(sdram.dq_oe), 16'h0);
        chk("mid_rst_dq",        sdram.dq_out,     16'h0);
        chk("mid_rst_init_done", 16'(init_done),   16'h0);
        chk("mid_rst_err_flag",  16'(err_flag),    16'h0);
        #1;
        rst_n = 1'b1;
        nop(2);
        chk("post_rst_oe", 16'(sdram.dq_oe), 16'h0);
        drive(CMD_READ, 2'd1, 13'h010, 16'h0);
        chk("post_rst_err_flag", 16'(err_flag), 16'h1);
        chk("post_rst_err_code", 16'(err_code), 16'h1);
        nop(3);
        chk("post_rst_no_data", 16'(sdram.dq_oe), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable SDRAM device-side responder: samples the command/address bus driven by the SDRAM controller's command generator, decodes it, tracks init sequence, mode register and per-bank open rows, and serves read/write bursts from a small on-chip backing store. Used in simulation and on-FPGA loopback to close the controller's command path without an external SDRAM, and to flag protocol violations.

## Interface
- MEM_AW, 10, backing-store address width (2^MEM_AW 16-bit words)
- T_RCD, 2, minimum cycles from ACTIVE to READ/WRITE on the same bank
- clk_100m  in  1  system clock; all sampling on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  in  1 each  command bus, as driven by the controller
- sdram_ba  in  2  bank address
- sdram_addr  in  13  row (ACTIVE), column in [8:0] plus A10 (READ/WRITE/PRECHARGE), mode (MRS)
- sdram_dq_in  in  16  write data from controller
- sdram_dq_out  out  16  read data
- sdram_dq_oe  out  1  read data valid / output enable
- init_done  out  1  init sequence completed
- err_flag  out  1  sticky protocol-violation flag
- err_code  out  3  code of most recent violation

## Operation
- Command = {cke, cs_n, ras_n, cas_n, we_n}: NOP 1_0111, ACTIVE 1_0011, READ 1_0101, WRITE 1_0100, BST 1_0110, PRECHARGE 1_0010, AUTO_REFRESH 1_0001, MRS 1_0000. cke=0 or cs_n=1: ignored (no state change).
- Init FSM: WAIT_PRE -> (PRECHARGE with A10=1) WAIT_AR1 -> (AUTO_REFRESH) WAIT_AR2 -> (AUTO_REFRESH) WAIT_MRS -> (MRS) READY. Any other non-NOP command before READY: err code 1, command ignored, state unchanged.
- Mode register (MRS): A9 write mode (1 = single write, 0 = burst write), A6:A4 CAS latency (010=2, 011=3), A3 must be 0 (sequential), A2:A0 burst length (000=1, 001=2, 010=4, 011=8, 111=full page). Other values: err code 6, mode unchanged.
- Per bank: open bit, 13-bit row, ACTIVE timestamp counter. ACTIVE to open bank: err 3, ignored. READ/WRITE to idle bank: err 2, ignored. READ/WRITE fewer than T_RCD cycles after ACTIVE: err 4, still executed. PRECHARGE: A10=1 closes all banks, else bank ba. AUTO_REFRESH or MRS with any bank open: err 5, ignored.
- Store index = low MEM_AW bits of {ba, row, col}; aliasing accepted. Contents undefined after power-up; not cleared by reset.
- Read: burst generator issues one column per cycle starting on the READ edge; column wraps 511 -> 0 inside the page. Stops after BL issues; full page runs until terminated.
- Write: dq_in sampled on WRITE edge; burst write continues on the following BL-1 edges, same wrap rule.
- READ, WRITE, BST or PRECHARGE terminates any active burst: no issue from that edge on; already-issued read words still emerge.
- WRITE while a read word is pending in the CL pipeline: err 7; write still performed.
- err_flag sticky until reset; err_code overwritten by each new violation.

## Timing
- Reset: dq_out=0, dq_oe=0, init_done=0, err_flag=0, err_code=0, all banks idle, init FSM WAIT_PRE, mode CL=3, BL=1, single write. Asserting rst_n low mid-burst clears dq_oe and burst state immediately.
- Read issued at edge T appears on dq_out with dq_oe=1 during cycle T+CL; gapless for consecutive issues.
- Write data at edge T is readable by a READ issued at T+1.
- init_done rises the cycle after the accepted MRS edge.
- err_flag/err_code update the cycle after the violating command edge.

## Structure
- Command encodings (CMD_*), mode-register field positions and error codes live in the shared sdram_para header used by the command generator.
- One sub-module: sdram_rd_pipe, CL-deep shift register of {valid, index} plus registered store read, producing dq_out/dq_oe.

## Test plan
- Init PRECHARGE(A10=1), AR, AR, MRS addr=0x232 -> init_done=1 next cycle, mode CL3/BL4/single write, err_flag=0.
- ACTIVE ba=1 row=0x005; WRITE col 0x010 dq_in=0xA5A5 two cycles later; READ col 0x010 at T -> dq_out=0xA5A5 at T+3, dq_oe high T+3..T+6 (cols 0x10..0x13).
- PRECHARGE all, MRS 0x237 (full page), ACTIVE, READ col 0x1FE at T, BST at T+4 -> words from cols 0x1FE, 0x1FF, 0x000, 0x001 at T+3..T+6; dq_oe=0 at T+7.
- MRS 0x222 (CL2) -> READ at T gives data at T+2.
- READ to idle bank 2 -> err_flag=1, err_code=2, dq_oe stays 0; ACTIVE then READ next cycle -> err_code=4, data still returned.
- rst_n low during read burst -> dq_oe=0 immediately, init_done=0; READ after release -> err_code=1.
